line_error_multiband: RTL and testbench
=======================================

Name: line_error_multiband

Overview:
- Streaming line-follower error extractor that generalises the single-window centroid error block.
- Splits a configurable region of interest (ROI) into NUM_BANDS horizontal bands.
- For each band, computes the centroid column of above-threshold pixels and emits a signed error against the image centre line, one band at a time.
- Sits between the camera pixel stream and the PID controller, which uses near and far bands for look-ahead steering.

Parameters:
- IMAGE_WIDTH, 320, pixels per row.
- IMAGE_HEIGHT, 240, rows per frame.
- NUM_BANDS, 4, number of horizontal bands; (ROI_Y_MAX-ROI_Y_MIN+1) must be divisible by NUM_BANDS.
- ROI_X_MIN, 106, first ROI column (inclusive).
- ROI_X_MAX, 210, last ROI column (inclusive).
- ROI_Y_MIN, 109, first ROI row (inclusive).
- ROI_Y_MAX, 228, last ROI row (inclusive).
- MIN_PIXELS, 8, minimum hit count for a band to count as found.
- ERR_WIDTH, 16, width of the signed error output.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pixel  in  12  RGB444 pixel, R=[11:8], G=[7:4], B=[3:0].
- valid  in  1  pixel beat qualifier; counters advance only when valid=1.
- startofpacket  in  1  marks pixel (0,0) of a frame; only meaningful when valid=1.
- channel_sel  in  2  selects the channel: 00=R, 01=G, 10=B, 11=any (hit if any channel passes).
- threshold  in  4  a pixel is a hit when the selected nibble >= threshold; sampled every beat.
- band_error  out  ERR_WIDTH  signed value, IMAGE_WIDTH/2 minus the band centroid.
- band_index  out  $clog2(NUM_BANDS)  band number of the current result; 0 is the topmost band.
- band_found  out  1  band hit count was >= MIN_PIXELS.
- band_valid  out  1  one-cycle strobe; band_error, band_index and band_found are valid.
- frame_done  out  1  one-cycle strobe, coincident with band_valid for band NUM_BANDS-1.
- overrun  out  1  sticky flag: a band closed while the divider was still busy.

Behaviour:
- Reset: all outputs are 0; row and column counters, accumulators, band counter and divider are cleared; the FSM goes to IDLE.
- Pixel counting:
  - A valid beat with startofpacket=1 is position (0,0) and is evaluated.
  - Column wraps from IMAGE_WIDTH-1 to 0 and increments the row.
  - After row IMAGE_HEIGHT-1, col IMAGE_WIDTH-1, beats are ignored until the next startofpacket.
- Accumulation: for a beat inside the ROI that is a hit, x_sum += col and count += 1.
  - x_sum width is $clog2(IMAGE_WIDTH)+$clog2(band pixels)+1.
  - count width is $clog2(band pixels)+1.
- Band close: a band closes on the beat at (last row of the band, ROI_X_MAX).
  - On close, x_sum and count are latched into the divider operands.
  - The accumulators clear in the same cycle; that closing beat's own hit goes into the latched values.
- FSM states:
  - IDLE -> ACCUM on startofpacket.
  - ACCUM -> DIVIDE on band close.
  - DIVIDE -> OUTPUT after SUM_W iterations.
  - OUTPUT -> ACCUM, or -> IDLE if this was the last band.
- Divider: sequential restoring divider, one quotient bit per cycle; the quotient is the floor of x_sum/count.
- Latency: band_valid asserts exactly SUM_W+2 clk cycles after the closing beat (SUM_W = x_sum width), independent of valid gaps.
- Result: band_error = IMAGE_WIDTH/2 - quotient, sign-extended to ERR_WIDTH.
  - If count < MIN_PIXELS, or count = 0: band_found=0, band_error=0, and no divide-by-zero occurs; latency is unchanged.
- Outputs hold their values between strobes; band_valid and frame_done are high for exactly one cycle.
- Overrun: if a band closes while in DIVIDE, overrun is set (sticky until reset).
  - The in-flight result completes normally.
  - The new band's operands are queued in one holding register; a further close drops data.
- startofpacket mid-frame, including during DIVIDE: the in-flight divide is aborted with no strobe for it, counters and accumulators restart, and band_index returns to 0.
- Reset mid-operation: immediate return to reset state; no strobe is emitted.

Test Plan:
- Green vertical line at col 150 on all rows, channel_sel=01, threshold=15 → 4 band_valid strobes, band_index 0..3, band_error=+10, band_found=1; frame_done together with band 3.
- Line at col 120 in rows 109-168 and col 200 in rows 169-228 → band_error = +40, +40, -40, -40.
- Line pixels with G=14: threshold=15 gives band_found=0 and error 0 for all bands; threshold=14 gives +10 for all bands.
- Scenario 1 with valid toggling 1/0 every cycle, plus random 10-cycle gaps → identical results; each strobe comes SUM_W+2 cycles after its closing beat.
- Hits only at cols 105 and 211 and at rows 108 and 229 → band_found=0 for all bands (outside ROI ignored).
- startofpacket 3 cycles after the band-0 close, then a clean frame → no strobe for the aborted band, the new frame's results are correct, overrun=0. Reset mid-DIVIDE → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/line_error_multiband.sv
// Multi-band line-follower error extractor: per-band centroid of above-threshold
// pixels inside an ROI, reported as a signed offset from the image centre column.
module line_error_multiband #(
    parameter int unsigned IMAGE_WIDTH  = 320,
    parameter int unsigned IMAGE_HEIGHT = 240,
    parameter int unsigned NUM_BANDS    = 4,
    parameter int unsigned ROI_X_MIN    = 106,
    parameter int unsigned ROI_X_MAX    = 210,
    parameter int unsigned ROI_Y_MIN    = 109,
    parameter int unsigned ROI_Y_MAX    = 228,
    parameter int unsigned MIN_PIXELS   = 8,
    parameter int unsigned ERR_WIDTH    = 16,
    localparam int unsigned BIDX_W      = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [11:0]                 pixel,
    input  logic                        valid,
    input  logic                        startofpacket,
    input  logic [1:0]                  channel_sel,
    input  logic [3:0]                  threshold,
    output logic signed [ERR_WIDTH-1:0] band_error,
    output logic [BIDX_W-1:0]           band_index,
    output logic                        band_found,
    output logic                        band_valid,
    output logic                        frame_done,
    output logic                        overrun
);
    localparam int unsigned COL_W    = $clog2(IMAGE_WIDTH);
    localparam int unsigned ROW_W    = $clog2(IMAGE_HEIGHT);
    localparam int unsigned BAND_H   = (ROI_Y_MAX - ROI_Y_MIN + 1) / NUM_BANDS;
    localparam int unsigned BAND_PIX = (ROI_X_MAX - ROI_X_MIN + 1) * BAND_H;
    localparam int unsigned CNT_W    = $clog2(BAND_PIX) + 1;
    localparam int unsigned SUM_W    = COL_W + CNT_W;
    localparam int unsigned IT_W     = $clog2(SUM_W);

    typedef enum logic [1:0] {StIdle, StAccum, StDivide, StOutput} state_t;
    state_t state_q, state_d;

    logic [COL_W-1:0]  col_q, cur_col;
    logic [ROW_W-1:0]  row_q, cur_row, end_row;
    logic              in_frame_q, sop_beat, beat, hit, in_roi, hit_roi, close;
    logic [BIDX_W-1:0] band_cnt_q, band_eff;
    logic [SUM_W-1:0]  x_sum_q, sum_in;
    logic [CNT_W-1:0]  cnt_q, cnt_in;

    logic [SUM_W-1:0]  div_q_q;
    logic [CNT_W-1:0]  div_rem_q, div_den_q, rem_nx;
    logic [CNT_W:0]    rem_sh, rem_sub;
    logic              rem_ge, div_found_q;
    logic [BIDX_W-1:0] div_band_q;
    logic [IT_W-1:0]   iter_q;

    logic              pend_v_q;
    logic [SUM_W-1:0]  pend_sum_q;
    logic [CNT_W-1:0]  pend_cnt_q;
    logic [BIDX_W-1:0] pend_band_q;

    logic                 load_new, load_pend, store_pend, emit, set_ovr;
    logic [ERR_WIDTH-1:0] err_calc;

    logic [ERR_WIDTH-1:0] band_error_q;
    logic [BIDX_W-1:0]    band_index_q;
    logic                 band_found_q, band_valid_q, frame_done_q, overrun_q;

    assign sop_beat = valid && startofpacket;
    assign beat     = valid && (sop_beat || in_frame_q);
    assign cur_col  = sop_beat ? '0 : col_q;
    assign cur_row  = sop_beat ? '0 : row_q;
    assign band_eff = sop_beat ? '0 : band_cnt_q;

    always_comb begin
        hit = 1'b0;
        unique case (channel_sel)
            2'b00: hit = pixel[11:8] >= threshold;
            2'b01: hit = pixel[7:4] >= threshold;
            2'b10: hit = pixel[3:0] >= threshold;
            2'b11: hit = (pixel[11:8] >= threshold) || (pixel[7:4] >= threshold) ||
                         (pixel[3:0] >= threshold);
        endcase
    end

    assign in_roi  = (cur_col >= COL_W'(ROI_X_MIN)) && (cur_col <= COL_W'(ROI_X_MAX)) &&
                     (cur_row >= ROW_W'(ROI_Y_MIN)) && (cur_row <= ROW_W'(ROI_Y_MAX));
    assign hit_roi = beat && in_roi && hit;
    assign end_row = ROW_W'(ROI_Y_MIN + BAND_H - 1) + ROW_W'(BAND_H) * ROW_W'(band_eff);
    assign close   = beat && (cur_col == COL_W'(ROI_X_MAX)) && (cur_row == end_row);

    // The closing beat's own hit is folded into the operands handed to the divider.
    assign sum_in = (sop_beat ? '0 : x_sum_q) + (hit_roi ? SUM_W'(cur_col) : '0);
    assign cnt_in = (sop_beat ? '0 : cnt_q) + {{(CNT_W-1){1'b0}}, hit_roi};

    assign rem_sh  = {div_rem_q, div_q_q[SUM_W-1]};
    assign rem_sub = rem_sh - {1'b0, div_den_q};
    assign rem_ge  = rem_sh >= {1'b0, div_den_q};
    assign rem_nx  = rem_ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];

    assign err_calc = ERR_WIDTH'(IMAGE_WIDTH / 2) - ERR_WIDTH'(div_q_q);

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_new   = 1'b0;
        load_pend  = 1'b0;
        store_pend = 1'b0;
        emit       = 1'b0;
        set_ovr    = 1'b0;
        if (sop_beat) begin
            // Frame restart aborts any in-flight divide without a strobe.
            state_d = StAccum;
            if (close) begin
                load_new = 1'b1;
                state_d  = StDivide;
            end
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StAccum: begin
                    if (close) begin
                        load_new = 1'b1;
                        state_d  = StDivide;
                    end
                end
                StDivide: begin
                    if (iter_q == IT_W'(SUM_W - 1)) state_d = StOutput;
                    if (close) begin
                        set_ovr    = 1'b1;
                        store_pend = !pend_v_q;
                    end
                end
                StOutput: begin
                    emit = 1'b1;
                    if (div_band_q == BIDX_W'(NUM_BANDS - 1)) begin
                        state_d = StIdle;
                    end else if (pend_v_q) begin
                        load_pend  = 1'b1;
                        store_pend = close;
                        state_d    = StDivide;
                    end else if (close) begin
                        load_new = 1'b1;
                        state_d  = StDivide;
                    end else begin
                        state_d = StAccum;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            in_frame_q <= 1'b0;
            band_cnt_q <= '0;
            x_sum_q    <= '0;
            cnt_q      <= '0;
        end else if (beat) begin
            if (cur_col == COL_W'(IMAGE_WIDTH - 1)) begin
                col_q      <= '0;
                row_q      <= cur_row + 1'b1;
                in_frame_q <= (cur_row != ROW_W'(IMAGE_HEIGHT - 1));
            end else begin
                col_q      <= cur_col + 1'b1;
                row_q      <= cur_row;
                in_frame_q <= 1'b1;
            end
            if (close) begin
                x_sum_q    <= '0;
                cnt_q      <= '0;
                band_cnt_q <= (band_eff == BIDX_W'(NUM_BANDS - 1)) ? '0 : band_eff + 1'b1;
            end else begin
                x_sum_q    <= sum_in;
                cnt_q      <= cnt_in;
                band_cnt_q <= band_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q_q     <= '0;
            div_rem_q   <= '0;
            div_den_q   <= '0;
            div_found_q <= 1'b0;
            div_band_q  <= '0;
            iter_q      <= '0;
            pend_v_q    <= 1'b0;
            pend_sum_q  <= '0;
            pend_cnt_q  <= '0;
            pend_band_q <= '0;
        end else begin
            if (load_new || load_pend) begin
                div_q_q     <= load_new ? sum_in : pend_sum_q;
                div_den_q   <= load_new ? cnt_in : pend_cnt_q;
                div_band_q  <= load_new ? band_eff : pend_band_q;
                div_found_q <= load_new ?
                    ((cnt_in >= CNT_W'(MIN_PIXELS)) && (cnt_in != '0)) :
                    ((pend_cnt_q >= CNT_W'(MIN_PIXELS)) && (pend_cnt_q != '0));
                div_rem_q   <= '0;
                iter_q      <= '0;
            end else if (state_q == StDivide) begin
                div_q_q   <= {div_q_q[SUM_W-2:0], rem_ge};
                div_rem_q <= rem_nx;
                iter_q    <= iter_q + 1'b1;
            end
            if (load_pend || sop_beat) pend_v_q <= 1'b0;
            if (store_pend) begin
                pend_v_q    <= 1'b1;
                pend_sum_q  <= sum_in;
                pend_cnt_q  <= cnt_in;
                pend_band_q <= band_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            band_error_q <= '0;
            band_index_q <= '0;
            band_found_q <= 1'b0;
            band_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            band_valid_q <= emit;
            frame_done_q <= emit && (div_band_q == BIDX_W'(NUM_BANDS - 1));
            if (set_ovr) overrun_q <= 1'b1;
            if (emit) begin
                band_error_q <= div_found_q ? err_calc : '0;
                band_index_q <= div_band_q;
                band_found_q <= div_found_q;
            end
        end
    end

    assign band_error = band_error_q;
    assign band_index = band_index_q;
    assign band_found = band_found_q;
    assign band_valid = band_valid_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_line_error_multiband.sv
// Bench for line_error_multiband on a reduced image geometry so whole frames stay short.
module tb_line_error_multiband;
    localparam int W = 64, H = 48, NB = 4, XMIN = 20, XMAX = 43, YMIN = 8, YMAX = 39;
    localparam int MINP = 4;
    localparam int BH = (YMAX - YMIN + 1) / NB;
    localparam int SUM_W = $clog2(W) + $clog2((XMAX - XMIN + 1) * BH) + 1;

    logic clk = 1'b0, reset;
    logic [11:0] pixel;
    logic valid, startofpacket;
    logic [1:0] channel_sel;
    logic [3:0] threshold;
    logic signed [15:0] band_error;
    logic [1:0] band_index;
    logic band_found, band_valid, frame_done, overrun;

    line_error_multiband #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .NUM_BANDS(NB), .ROI_X_MIN(XMIN),
        .ROI_X_MAX(XMAX), .ROI_Y_MIN(YMIN), .ROI_Y_MAX(YMAX), .MIN_PIXELS(MINP),
        .ERR_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .pixel(pixel), .valid(valid),
        .startofpacket(startofpacket), .channel_sel(channel_sel), .threshold(threshold),
        .band_error(band_error), .band_index(band_index), .band_found(band_found),
        .band_valid(band_valid), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int idx; int err; int found; } exp_t;
    typedef struct {
        int kind; int col_top; int col_bot; logic [11:0] hp; logic [1:0] sel;
        logic [3:0] th; bit gaps; int e0; int e1; int e2; int e3; int found;
    } vec_t;

    exp_t exp_q[$];
    int close_q[$];
    logic [11:0] img [0:W*H-1];
    logic [1:0] cur_sel;
    logic [3:0] cur_th;
    int total = 0, bad = 0;
    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit is_hit(logic [11:0] p, logic [1:0] sel, logic [3:0] th);
        case (sel)
            2'b00: return p[11:8] >= th;
            2'b01: return p[7:4] >= th;
            2'b10: return p[3:0] >= th;
            default: return (p[11:8] >= th) || (p[7:4] >= th) || (p[3:0] >= th);
        endcase
    endfunction

    // Reference: band centroid straight from the stored frame image.
    function automatic exp_t model_band(int b, logic [1:0] sel, logic [3:0] th);
        exp_t e;
        int n = 0, s = 0;
        for (int r = YMIN + b * BH; r < YMIN + (b + 1) * BH; r++)
            for (int c = XMIN; c <= XMAX; c++)
                if (is_hit(img[r*W+c], sel, th)) begin n++; s += c; end
        e.idx = b;
        e.found = (n >= MINP && n > 0) ? 1 : 0;
        e.err = e.found ? (W / 2 - s / n) : 0;
        return e;
    endfunction

    function automatic bit is_close(int r, int c);
        return (c == XMAX) && (r >= YMIN) && (r <= YMAX) && ((r - YMIN) % BH == BH - 1);
    endfunction

    task automatic fill_line(input int ct, input int cb, input logic [11:0] hp);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r*W+c] = (c == ((r < YMIN + 2 * BH) ? ct : cb)) ? hp : 12'h000;
    endtask

    task automatic fill_outside(input logic [11:0] hp);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r*W+c] = (c == XMIN - 1 || c == XMAX + 1 || r == YMIN - 1 || r == YMAX + 1)
                             ? hp : 12'h000;
    endtask

    task automatic push_exp(input int e0, input int e1, input int e2, input int e3,
                            input int f);
        int ev[4];
        ev = '{e0, e1, e2, e3};
        for (int b = 0; b < NB; b++) exp_q.push_back('{b, ev[b], f});
    endtask

    // stop_after >= 0: abandon the frame that many cycles after the first band close.
    task automatic drive_frame(input bit gaps, input int stop_after);
        bit seen = 0;
        int since = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (seen) begin
                    since++;
                    if (since == stop_after) return;
                end
                pixel = img[r*W+c];
                valid = 1'b1;
                startofpacket = (r == 0 && c == 0);
                channel_sel = cur_sel;
                threshold = cur_th;
                if (is_close(r, c)) begin
                    close_q.push_back(cyc);
                    seen = 1;
                end
                @(posedge clk); #1;
                valid = 1'b0;
                startofpacket = 1'b0;
                if (gaps) begin
                    pixel = 12'($urandom);
                    @(posedge clk); #1;
                    if ($urandom_range(0, 199) == 0) repeat (10) begin @(posedge clk); #1; end
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        close_q.delete();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done && !band_valid) chk("frame_done_alone", 1, 0);
            if (band_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", int'(band_index), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("band_index", int'(band_index), e.idx);
                    chk("band_error", int'(band_error), e.err);
                    chk("band_found", int'(band_found), e.found);
                    chk("frame_done", int'(frame_done), (e.idx == NB - 1) ? 1 : 0);
                    chk("overrun", int'(overrun), 0);
                    if (close_q.size() != 0) chk("latency", cyc - close_q.pop_front(), SUM_W + 2);
                    else chk("latency_missing_close", 0, 1);
                end
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_err"}, int'(band_error), 0);
        chk({tag, "_idx"}, int'(band_index), 0);
        chk({tag, "_found"}, int'(band_found), 0);
        chk({tag, "_valid"}, int'(band_valid), 0);
        chk({tag, "_fd"}, int'(frame_done), 0);
        chk({tag, "_ovr"}, int'(overrun), 0);
    endtask

    initial begin
        vecs[0] = '{0, 22, 22, 12'h0F0, 2'b01, 4'd15, 1'b0, 10, 10, 10, 10, 1};
        vecs[1] = '{0, 24, 40, 12'h0F0, 2'b01, 4'd15, 1'b0, 8, 8, -8, -8, 1};
        vecs[2] = '{0, 22, 22, 12'h0E0, 2'b01, 4'd15, 1'b0, 0, 0, 0, 0, 0};
        vecs[3] = '{0, 22, 22, 12'h0E0, 2'b01, 4'd14, 1'b0, 10, 10, 10, 10, 1};
        vecs[4] = '{0, 22, 22, 12'h0F0, 2'b01, 4'd15, 1'b1, 10, 10, 10, 10, 1};
        vecs[5] = '{1, 0, 0, 12'h0F0, 2'b01, 4'd15, 1'b0, 0, 0, 0, 0, 0};
        vecs[6] = '{0, 22, 22, 12'hA00, 2'b11, 4'd9, 1'b0, 10, 10, 10, 10, 1};
        vecs[7] = '{0, 30, 30, 12'h00C, 2'b10, 4'd12, 1'b0, 2, 2, 2, 2, 1};
        vecs[8] = '{0, 30, 30, 12'h00C, 2'b00, 4'd12, 1'b0, 0, 0, 0, 0, 0};

        reset = 1'b1; valid = 1'b0; startofpacket = 1'b0; pixel = '0;
        channel_sel = '0; threshold = '0; cur_sel = 2'b01; cur_th = 4'd15;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_zero_outputs("reset");

        foreach (vecs[v]) begin
            if (vecs[v].kind == 0) fill_line(vecs[v].col_top, vecs[v].col_bot, vecs[v].hp);
            else fill_outside(vecs[v].hp);
            cur_sel = vecs[v].sel;
            cur_th = vecs[v].th;
            push_exp(vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].found);
            drive_frame(vecs[v].gaps, -1);
            wait_drain();
        end

        for (int f = 0; f < 3; f++) begin
            int p;
            p = (f == 0) ? 1 : ((f == 1) ? 6 : 40);
            for (int i = 0; i < W * H; i++)
                img[i] = ($urandom_range(0, p - 1) == 0) ? 12'($urandom) : 12'h000;
            cur_sel = 2'($urandom);
            cur_th = 4'($urandom_range(1, 15));
            for (int b = 0; b < NB; b++) exp_q.push_back(model_band(b, cur_sel, cur_th));
            drive_frame(f == 1, -1);
            wait_drain();
        end

        // Restart a frame three cycles after the first band closes.
        fill_line(22, 22, 12'h0F0);
        cur_sel = 2'b01; cur_th = 4'd15;
        drive_frame(1'b0, 3);
        void'(close_q.pop_back());
        fill_line(24, 40, 12'h0F0);
        push_exp(8, 8, -8, -8, 1);
        drive_frame(1'b0, -1);
        wait_drain();
        chk("overrun_after_abort", int'(overrun), 0);

        // Reset while the band-0 divide is in flight.
        fill_line(22, 22, 12'h0F0);
        drive_frame(1'b0, 5);
        close_q.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midreset");
        repeat (SUM_W + 10) @(posedge clk);
        #1;
        push_exp(10, 10, 10, 10, 1);
        drive_frame(1'b0, -1);
        wait_drain();
        chk("overrun_end", int'(overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
